// File: rtl/nand_seq.sv
// nand_seq: single-plane NAND page program / page read sequencer.
//
// Drives one NAND device through a full page operation:
//   program: 80h, 5 address cycles, PAGE_BYTES data, 10h, tWB, R/B wait, 70h, status read
//   read   : 00h, 5 address cycles, 30h, tWB, R/B wait, PAGE_BYTES data into the sink FIFO
//
// Ports
//   clk, rst_n                 system clock, asynchronous active-low reset
//   op_start/op_prog/op_addr   request pulse, 1=program 0=read, {row[39:16], column[15:0]}
//   op_busy/op_done/op_err     operation active, completion pulse, status-fail/timeout flag
//   fifo_rd_en/dout/empty      program-data source (data valid the cycle after rd_en)
//   fifo_wr_en/din/full        read-data sink
//   io_io_in/steed_io_out/oe   NAND IO bus
//   io_rxb                     NAND ready(1)/busy(0)
//   io_ale/cle/xce/xre/xwe     NAND control strobes
//
// Optional feature: define NAND_RB_TIMEOUT_EN to add a 20-bit ready/busy timeout
// that ends the operation with op_err=1; without it the R/B wait is unbounded.
module nand_seq #(
  parameter int PAGE_BYTES = 2048,
  parameter int T_LO       = 2,
  parameter int T_HI       = 2,
  parameter int T_WB       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_start,
  input  logic        op_prog,
  input  logic [39:0] op_addr,
  output logic        op_busy,
  output logic        op_done,
  output logic        op_err,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_din,
  input  logic        fifo_full,
  input  logic [7:0]  io_io_in,
  output logic [7:0]  steed_io_out,
  output logic        steed_io_oe,
  input  logic        io_rxb,
  output logic        io_ale,
  output logic        io_cle,
  output logic        io_xce,
  output logic        io_xre,
  output logic        io_xwe
);

  localparam int TCYC = T_LO + T_HI;
  localparam int TW   = $clog2(TCYC + 1);
  localparam int WBW  = $clog2(T_WB + 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(TCYC - 1);
  localparam logic [TW-1:0]  T_SMP   = TW'(T_LO - 1);
  localparam logic [TW-1:0]  T_LOW   = TW'(T_LO);
  localparam logic [WBW-1:0] WB_LAST = WBW'(T_WB - 1);
  localparam logic [12:0]    B_LAST  = 13'(PAGE_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, CMD1, ADDR, WDATA, CMD2, WAIT_WB, WAIT_RB, RDATA, STAT_CMD, STAT_RD, DONE
  } state_t;

  state_t state, state_n;

  logic           prog_q;
  logic [39:0]    addr_q;
  logic [TW-1:0]  tcnt;
  logic [2:0]     idx;
  logic [12:0]    bcnt;
  logic [WBW-1:0] wbcnt;
  logic [7:0]     data_q;
  logic           have_byte;
  logic           rd_pend;
  logic [7:0]     rdata_q;
  logic           wr_pend;
  logic           err_q;
  logic [7:0]     addr_byte;

  logic strobe_on, re_strobe, cyc_end, cyc_done, start_acc, smp, to_hit;

`ifdef NAND_RB_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'hFFFFE;
  logic [19:0] to_cnt;
`endif

  assign cyc_end  = (tcnt == T_LAST);
  assign smp      = strobe_on && re_strobe && (tcnt == T_SMP);
  assign io_xwe   = !(strobe_on && !re_strobe && (tcnt < T_LOW));
  assign io_xre   = !(strobe_on && re_strobe && (tcnt < T_LOW));
  assign op_err   = err_q;
  assign fifo_din = rdata_q;

  always_comb begin
    case (idx)
      3'd0:    addr_byte = addr_q[7:0];
      3'd1:    addr_byte = addr_q[15:8];
      3'd2:    addr_byte = addr_q[23:16];
      3'd3:    addr_byte = addr_q[31:24];
      default: addr_byte = addr_q[39:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    steed_io_out = 8'h00;
    steed_io_oe  = 1'b0;
    io_cle       = 1'b0;
    io_ale       = 1'b0;
    io_xce       = 1'b0;
    op_busy      = 1'b1;
    op_done      = 1'b0;
    fifo_rd_en   = 1'b0;
    fifo_wr_en   = 1'b0;
    strobe_on    = 1'b0;
    re_strobe    = 1'b0;
    cyc_done     = 1'b0;
    start_acc    = 1'b0;
    to_hit       = 1'b0;
    case (state)
      IDLE: begin
        io_xce  = 1'b1;
        op_busy = 1'b0;
        if (op_start) begin
          start_acc = 1'b1;
          state_n   = CMD1;
        end
      end
      CMD1: begin
        io_cle       = 1'b1;
        steed_io_oe  = 1'b1;
        steed_io_out = prog_q ? 8'h80 : 8'h00;
        strobe_on    = 1'b1;
        if (cyc_end) begin
          cyc_done = 1'b1;
          state_n  = ADDR;
        end
      end
      ADDR: begin
        io_ale       = 1'b1;
        steed_io_oe  = 1'b1;
        steed_io_out = addr_byte;
        strobe_on    = 1'b1;
        if (cyc_end) begin
          cyc_done = 1'b1;
          if (idx == 3'd4) state_n = prog_q ? WDATA : CMD2;
        end
      end
      WDATA: begin
        // Bus stays driven for the whole page; xWE only pulses once a byte is held.
        steed_io_oe  = 1'b1;
        steed_io_out = data_q;
        if (have_byte) begin
          strobe_on = 1'b1;
          if (cyc_end) begin
            cyc_done = 1'b1;
            if (bcnt == B_LAST) state_n = CMD2;
          end
        end else if (!rd_pend && !fifo_empty) begin
          fifo_rd_en = 1'b1;
        end
      end
      CMD2: begin
        io_cle       = 1'b1;
        steed_io_oe  = 1'b1;
        steed_io_out = prog_q ? 8'h10 : 8'h30;
        strobe_on    = 1'b1;
        if (cyc_end) begin
          cyc_done = 1'b1;
          state_n  = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (wbcnt == WB_LAST) state_n = WAIT_RB;
      end
      WAIT_RB: begin
        if (io_rxb) state_n = prog_q ? STAT_CMD : RDATA;
`ifdef NAND_RB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          to_hit  = 1'b1;
          state_n = DONE;
        end
`endif
      end
      RDATA: begin
        // A captured byte must reach the sink before the next xRE pulse;
        // while the sink is full the timer parks on its last (high) count.
        strobe_on  = 1'b1;
        re_strobe  = 1'b1;
        fifo_wr_en = wr_pend && !fifo_full;
        if (cyc_end && (!wr_pend || !fifo_full)) begin
          cyc_done = 1'b1;
          if (bcnt == B_LAST) state_n = DONE;
        end
      end
      STAT_CMD: begin
        io_cle       = 1'b1;
        steed_io_oe  = 1'b1;
        steed_io_out = 8'h70;
        strobe_on    = 1'b1;
        if (cyc_end) begin
          cyc_done = 1'b1;
          state_n  = STAT_RD;
        end
      end
      STAT_RD: begin
        strobe_on = 1'b1;
        re_strobe = 1'b1;
        if (cyc_end) begin
          cyc_done = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        op_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_q    <= 1'b0;
      tcnt      <= '0;
      idx       <= '0;
      bcnt      <= '0;
      wbcnt     <= '0;
      have_byte <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (start_acc) prog_q <= op_prog;

      if (cyc_done)                  tcnt <= '0;
      else if (strobe_on && !cyc_end) tcnt <= tcnt + 1'b1;

      if (start_acc)                       idx <= '0;
      else if (state == ADDR && cyc_done)  idx <= idx + 1'b1;

      if (start_acc) bcnt <= '0;
      else if ((state == WDATA || state == RDATA) && cyc_done)
        bcnt <= (bcnt == B_LAST) ? 13'd0 : bcnt + 1'b1;

      if (state == WAIT_WB) wbcnt <= wbcnt + 1'b1;
      else                  wbcnt <= '0;

      // Source FIFO data lands one cycle after the read enable.
      rd_pend <= fifo_rd_en;
      if (rd_pend)       have_byte <= 1'b1;
      else if (cyc_done) have_byte <= 1'b0;

      if (state == RDATA && smp) wr_pend <= 1'b1;
      else if (fifo_wr_en)       wr_pend <= 1'b0;

      if (start_acc)                   err_q <= 1'b0;
      else if (state == STAT_RD && smp) err_q <= io_io_in[0];
      else if (to_hit)                  err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc)              addr_q  <= op_addr;
    if (rd_pend)                data_q  <= fifo_dout;
    if (state == RDATA && smp)  rdata_q <= io_io_in;
  end

`ifdef NAND_RB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         to_cnt <= '0;
    else if (state == WAIT_RB && !io_rxb) to_cnt <= to_cnt + 1'b1;
    else                                to_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_nand_seq.sv
// tb_nand_seq: directed bench for nand_seq with a small NAND device model,
// a source FIFO model for program data and a sink FIFO model for read data.
module tb_nand_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_start = 1'b0;
  logic        op_prog = 1'b0;
  logic [39:0] op_addr = '0;
  logic        op_busy, op_done, op_err;
  logic        fifo_rd_en, fifo_wr_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic [7:0]  fifo_din;
  logic        fifo_full = 1'b0;
  logic [7:0]  io_io_in;
  logic [7:0]  steed_io_out;
  logic        steed_io_oe, io_rxb, io_ale, io_cle, io_xce, io_xre, io_xwe;

  nand_seq #(.PAGE_BYTES(4), .T_LO(2), .T_HI(2), .T_WB(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_start(op_start), .op_prog(op_prog), .op_addr(op_addr),
    .op_busy(op_busy), .op_done(op_done), .op_err(op_err),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .io_io_in(io_io_in), .steed_io_out(steed_io_out), .steed_io_oe(steed_io_oe),
    .io_rxb(io_rxb), .io_ale(io_ale), .io_cle(io_cle), .io_xce(io_xce),
    .io_xre(io_xre), .io_xwe(io_xwe)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Source FIFO: four bytes per page, stall forces empty.
  logic [7:0] wdata [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int  wptr = 0;
  int  wbase = 0;
  logic stall = 1'b0;
  assign fifo_empty = ((wptr - wbase) >= 4) || stall;
  always @(posedge clk) if (fifo_rd_en) begin
    fifo_dout <= wdata[(wptr - wbase) & 3];
    wptr <= wptr + 1;
  end

  // Sink FIFO.
  logic [7:0] sink [$];
  always @(posedge clk) if (fifo_wr_en && !fifo_full) sink.push_back(fifo_din);

  // NAND model: logs every xWE-latched bus cycle as {cle, ale, data}.
  logic [9:0] bus_log [$];
  logic [9:0] exp_log [$];
  logic [7:0] rd_bytes [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] status_byte = 8'h00;
  int  busy_cnt = 0;
  int  re_cnt = 0;
  int  re_base = 0;
  int  done_cnt = 0;
  logic done_err = 1'b0;
  int  both_bad = 0;
  int  stall_cyc = 0, stall_bad = 0;
  int  full_cyc = 0, full_bad = 0;
  logic prev_xwe = 1'b1, prev_xre = 1'b1;

  assign io_rxb   = (busy_cnt == 0);
  assign io_io_in = (last_cmd == 8'h70) ? status_byte : rd_bytes[(re_cnt - re_base) & 3];

  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (!prev_xwe && io_xwe) begin
      bus_log.push_back({io_cle, io_ale, steed_io_out});
      if (io_cle) last_cmd = steed_io_out;
      if (io_cle && (steed_io_out == 8'h10 || steed_io_out == 8'h30)) busy_cnt = 10;
    end
    if (!prev_xre && io_xre) re_cnt = re_cnt + 1;
    if (io_cle && io_ale) both_bad = both_bad + 1;
    if (op_done) begin
      done_cnt = done_cnt + 1;
      done_err = op_err;
    end
    if (stall) begin
      if (stall_cyc >= 10 && !io_xwe) stall_bad = stall_bad + 1;
      stall_cyc = stall_cyc + 1;
    end
    if (fifo_full) begin
      if (full_cyc >= 6 && !io_xre) full_bad = full_bad + 1;
      full_cyc = full_cyc + 1;
    end
    prev_xwe = io_xwe;
    prev_xre = io_xre;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic prog, input logic [39:0] addr);
    @(negedge clk);
    op_prog  = prog;
    op_addr  = addr;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt != d0), 1'b1);
  endtask

  task automatic wait_fetch(input int k);
    int n = 0;
    while ((wptr - wbase) < k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_reached", ((wptr - wbase) >= k), 1'b1);
  endtask

  task automatic check_log(input string tag, input int start);
    chk({tag, "_len"}, bus_log.size() - start, exp_log.size());
    foreach (exp_log[i]) begin
      chk($sformatf("%s_bus%0d", tag, i),
          (start + i < bus_log.size()) ? bus_log[start + i] : 10'h3FF, exp_log[i]);
    end
  endtask

  function automatic void prog_exp();
    exp_log = '{10'h280, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101,
                10'h011, 10'h022, 10'h033, 10'h044, 10'h210, 10'h270};
  endfunction

  initial begin
    int ls, d0, r0, s0;

    // Reset state: {xce, xwe, xre, ale, cle, oe, busy, done, err, rd_en, wr_en}
    #12;
    chk("rst_ctrl", {io_xce, io_xwe, io_xre, io_ale, io_cle, steed_io_oe, op_busy,
                     op_done, op_err, fifo_rd_en, fifo_wr_en}, 11'b111_0000_0000);
    chk("rst_bus", steed_io_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Program with status pass; a second start while busy is ignored.
    prog_exp();
    ls = bus_log.size(); d0 = done_cnt; r0 = re_cnt; status_byte = 8'h00;
    start_op(1'b1, 40'h01_0203_0405);
    chk("prog_busy", op_busy, 1'b1);
    chk("prog_xce", io_xce, 1'b0);
    repeat (3) @(negedge clk);
    start_op(1'b0, 40'hFF_FFFF_FFFF);
    wait_done("prog", d0);
    chk("prog_err", done_err, 1'b0);
    repeat (3) @(negedge clk);
    chk("prog_done_once", done_cnt - d0, 1);
    chk("prog_idle_busy", op_busy, 1'b0);
    chk("prog_idle_xce", io_xce, 1'b1);
    chk("prog_re_cnt", re_cnt - r0, 1);
    chk("prog_fifo_used", wptr - wbase, 4);
    check_log("prog", ls);

    // Read: sink gets A0..A3; sink full for a while after the first byte.
    exp_log = '{10'h200, 10'h155, 10'h144, 10'h133, 10'h122, 10'h111, 10'h230};
    ls = bus_log.size(); d0 = done_cnt; re_base = re_cnt; s0 = sink.size();
    start_op(1'b0, 40'h11_2233_4455);
    begin
      int n = 0;
      while ((re_cnt - re_base) < 1 && n < 3000) begin @(negedge clk); n++; end
    end
    fifo_full = 1'b1;
    repeat (20) @(negedge clk);
    fifo_full = 1'b0;
    wait_done("read", d0);
    chk("read_err", done_err, 1'b0);
    chk("read_full_xre", full_bad, 0);
    chk("read_sink_n", sink.size() - s0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("read_sink%0d", i), (s0 + i < sink.size()) ? sink[s0 + i] : 8'hXX,
          8'hA0 + 8'(i));
    chk("read_re_cnt", re_cnt - re_base, 4);
    check_log("read", ls);

    // Program with a 50-cycle source stall after two bytes; status fail 01h.
    prog_exp();
    wbase = wptr; ls = bus_log.size(); d0 = done_cnt; status_byte = 8'h01;
    start_op(1'b1, 40'h01_0203_0405);
    wait_fetch(2);
    stall = 1'b1;
    repeat (50) @(negedge clk);
    stall = 1'b0;
    wait_done("stall", d0);
    chk("stall_err", done_err, 1'b1);
    chk("stall_xwe_high", stall_bad, 0);
    chk("stall_fifo_used", wptr - wbase, 4);
    check_log("stall", ls);

    // Reset during the second data byte aborts at once with no completion.
    wbase = wptr; d0 = done_cnt; status_byte = 8'h00;
    start_op(1'b1, 40'h01_0203_0405);
    wait_fetch(2);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {io_xce, io_xwe, io_xre, io_ale, io_cle, steed_io_oe, op_busy,
                       op_done, op_err, fifo_rd_en, fifo_wr_en}, 11'b111_0000_0000);
    chk("abort_bus", steed_io_out, 8'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", op_busy, 1'b0);

    // Fresh program after the abort completes normally.
    prog_exp();
    wbase = wptr; ls = bus_log.size(); d0 = done_cnt;
    start_op(1'b1, 40'h01_0203_0405);
    wait_done("again", d0);
    chk("again_err", done_err, 1'b0);
    check_log("again", ls);
    chk("cle_ale_excl", both_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nand_seq.md
NAND_SEQ -- requirements
Module: nand_seq

Interface
REQ-001 Parameter: PAGE_BYTES, 2048, data bytes moved per page operation (1..4096).
REQ-002 Parameter: T_LO, 2, clk cycles xWE/xRE held low per strobe (>=1).
REQ-003 Parameter: T_HI, 2, clk cycles xWE/xRE held high between strobes (>=1).
REQ-004 Parameter: T_WB, 4, clk cycles ignored on io_rxb after the confirm command (>=1).
REQ-005 Ports: clk  in  1  system clock from ocs_clk. One clock; reset is asynchronous and active-low.
REQ-006 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 Ports: op_start  in  1  one-cycle start pulse; op_prog  in  1  1=page program, 0=page read (sampled with op_start).
REQ-008 Ports: op_addr  in  40  column[15:0] and row[39:16]; sent LSB byte first as 5 address cycles.
REQ-009 Ports: op_busy  out  1  operation active; op_done  out  1  one-cycle completion pulse; op_err  out  1  status-fail/timeout flag, valid with op_done.
REQ-010 Ports: fifo_rd_en  out  1 / fifo_dout  in  8 / fifo_empty  in  1  program-data source.
REQ-011 Ports: fifo_wr_en  out  1 / fifo_din  out  8 / fifo_full  in  1  read-data sink.
REQ-012 Ports: io_io_in  in  8 / steed_io_out  out  8 / steed_io_oe  out  1  NAND IO bus.
REQ-013 Ports: io_rxb  in  1  NAND ready(1)/busy(0); io_ale, io_cle, io_xce, io_xre, io_xwe  out  1 each.

Function
REQ-014 States: IDLE, CMD1, ADDR, WDATA, CMD2, WAIT_WB, WAIT_RB, RDATA, STAT_CMD, STAT_RD, DONE.
REQ-015 op_start in IDLE latches op_prog/op_addr and enters CMD1 next cycle; op_start outside IDLE is ignored.
REQ-016 Every bus cycle = T_LO low + T_HI high strobe; write cycles drive steed_io_oe=1 for whole cycle, data stable throughout.
REQ-017 CMD cycles assert io_cle; ADDR cycles assert io_ale; never both; io_xce=0 from CMD1 through DONE.
REQ-018 Program: CMD1=80h, 5 ADDR, WDATA PAGE_BYTES bytes, CMD2=10h, WAIT_WB, WAIT_RB, STAT_CMD=70h, STAT_RD one xRE cycle.
REQ-019 Read: CMD1=00h, 5 ADDR, CMD2=30h, WAIT_WB, WAIT_RB, RDATA PAGE_BYTES bytes, DONE (no status).
REQ-020 WDATA: fifo_rd_en pulses one cycle when fifo_empty=0 at byte start; fifo_dout registered next cycle; strobe starts only after byte captured; empty stalls with xWE high, no timeout.
REQ-021 RDATA: io_io_in sampled on last xRE-low cycle; fifo_wr_en pulses one cycle with fifo_din only if fifo_full=0, else xRE held high until not full.
REQ-022 Byte counter 12+1 bits, terminates at exactly PAGE_BYTES; no wrap.
REQ-023 WAIT_RB exits on first cycle io_rxb=1 after T_WB elapsed.
REQ-024 STAT_RD: op_err=io_io_in[0]; read ops op_err=0 unless timeout.
REQ-025 DONE: op_done=1 one cycle, io_xce=1, op_busy=0 following cycle, return IDLE; op_busy=1 from CMD1 through DONE.

Reset
REQ-026 rst_n low asynchronously forces IDLE, io_xce=io_xwe=io_xre=1, io_ale=io_cle=0, steed_io_oe=0, steed_io_out=00h, fifo_rd_en=fifo_wr_en=0, op_busy=op_done=op_err=0, counters 0.
REQ-027 Reset mid-operation aborts immediately; no op_done generated; FIFO contents untouched.

Configuration
REQ-028 Macro NAND_RB_TIMEOUT_EN defined: 20-bit counter in WAIT_RB; reaching 2^20-1 cycles with io_rxb=0 sets op_err=1 and goes DONE (skips RDATA/STAT).
REQ-029 Macro undefined: WAIT_RB waits indefinitely; no timeout logic synthesized.

Verification
REQ-030 Program, PAGE_BYTES=4, addr 0x0102030405, FIFO holds 11,22,33,44, status 00h -> bus 80h,05,04,03,02,01,11,22,33,44,10h,70h; op_err=0, op_done once.
REQ-031 Read, PAGE_BYTES=4, model returns A0..A3 -> bus 00h,5 addr,30h; FIFO receives A0,A1,A2,A3; four fifo_wr_en pulses.
REQ-032 Program with fifo_empty=1 for 50 cycles mid-page -> xWE high during stall, no lost/duplicated byte.
REQ-033 Status byte 01h -> op_err=1 with op_done.
REQ-034 Assert rst_n=0 during WDATA byte 2 -> all outputs reset values same cycle, no op_done; new op_start afterwards completes normally.
REQ-035 With NAND_RB_TIMEOUT_EN, io_rxb stuck 0 -> op_done with op_err=1 after 2^20-1 WAIT_RB cycles; op_start during op_busy ignored.
